mux_uart: RTL and testbench

- Memory-mapped serial port on the CPU6 memory bus, downstream of the CPU's address, write-data and write-enable outputs.
- Decodes two byte registers at BASE and BASE+1.
- Serialises CPU writes through a small TX FIFO onto an 8N1 line.
- Deserialises the RX line into a holding register that the CPU reads back over its data-in bus.

---
 rtl/mux_uart.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mux_uart.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_uart.sv
// Memory-mapped 8N1 serial port: status/data byte registers at BASE/BASE+1,
// a small TX FIFO feeding the transmitter, and a single-byte RX holding register.
module mux_uart #(
  parameter logic [15:0] BASE         = 16'hF200,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  writeDataBus,
  input  logic        writeEnBus,
  output logic [7:0]  readDataBus,
  output logic        selected,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic r_we_q;
  logic w_wr_pulse, w_sel_stat, w_sel_data, w_wr_stat, w_wr_data;

  assign w_wr_pulse = writeEnBus & ~r_we_q;
  assign w_sel_stat = (addressBus == BASE);
  assign w_sel_data = (addressBus == BASE + 16'd1);
  assign w_wr_stat  = w_wr_pulse & w_sel_stat;
  assign w_wr_data  = w_wr_pulse & w_sel_data;

  // TX FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          w_empty, w_full, w_push, w_drop, w_tx_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_push  = w_wr_data & (~w_full | w_tx_pop);
  assign w_drop  = w_wr_data & w_full & ~w_tx_pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we_q  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_we_q <= writeEnBus;
      if (w_push)   r_wptr <= r_wptr + PW'(1);
      if (w_tx_pop) r_rptr <= r_rptr + PW'(1);
      if (w_push & ~w_tx_pop)      r_count <= r_count + (PW + 1)'(1);
      else if (~w_push & w_tx_pop) r_count <= r_count - (PW + 1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= writeDataBus;
  end

  // TX FSM
  state_t        r_tx_state, w_tx_state_n;
  logic [CW-1:0] r_tx_baud, w_tx_baud_n;
  logic [2:0]    r_tx_bit, w_tx_bit_n;
  logic [7:0]    r_tx_shift;
  logic          r_tx, w_tx_n, w_tx_load, w_tx_shift_en, w_tx_end, w_tx_idle;

  assign w_tx_end  = (r_tx_baud == BAUD_LAST);
  assign w_tx_idle = w_empty & (r_tx_state == S_IDLE);

  always_comb begin
    w_tx_state_n  = r_tx_state;
    w_tx_baud_n   = r_tx_baud + CW'(1);
    w_tx_bit_n    = r_tx_bit;
    w_tx_pop      = 1'b0;
    w_tx_load     = 1'b0;
    w_tx_shift_en = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_baud_n = '0;
        if (!w_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_load    = 1'b1;
          w_tx_state_n = S_START;
        end
      end
      S_START: if (w_tx_end) begin
        w_tx_baud_n  = '0;
        w_tx_bit_n   = '0;
        w_tx_state_n = S_DATA;
      end
      S_DATA: if (w_tx_end) begin
        w_tx_baud_n = '0;
        if (r_tx_bit == 3'd7) w_tx_state_n = S_STOP;
        else begin
          w_tx_bit_n    = r_tx_bit + 3'd1;
          w_tx_shift_en = 1'b1;
        end
      end
      S_STOP: if (w_tx_end) begin
        w_tx_baud_n = '0;
        if (!w_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_load    = 1'b1;
          w_tx_state_n = S_START;
        end else begin
          w_tx_state_n = S_IDLE;
        end
      end
      default: w_tx_state_n = S_IDLE;
    endcase
    // Line level is registered from the next state so tx never glitches.
    w_tx_n = 1'b1;
    if (w_tx_state_n == S_START)     w_tx_n = 1'b0;
    else if (w_tx_state_n == S_DATA) w_tx_n = w_tx_shift_en ? r_tx_shift[1] : r_tx_shift[0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_state <= S_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_n;
      r_tx_baud  <= w_tx_baud_n;
      r_tx_bit   <= w_tx_bit_n;
      r_tx       <= w_tx_n;
    end
  end

  always_ff @(posedge clock) begin
    if (w_tx_load)          r_tx_shift <= r_mem[r_rptr];
    else if (w_tx_shift_en) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
  end

  // RX synchroniser and FSM
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  state_t        r_rx_state, w_rx_state_n;
  logic [CW-1:0] r_rx_baud, w_rx_baud_n;
  logic [2:0]    r_rx_bit, w_rx_bit_n;
  logic          r_rx_brk, w_rx_brk_n;
  logic [7:0]    r_rx_shift;
  logic          w_rx_shift_en, w_rx_done, w_rx_ferr, w_rx_end;

  assign w_rx_end = (r_rx_baud == BAUD_LAST);

  always_comb begin
    w_rx_state_n  = r_rx_state;
    w_rx_baud_n   = r_rx_baud + CW'(1);
    w_rx_bit_n    = r_rx_bit;
    w_rx_brk_n    = r_rx_brk;
    w_rx_shift_en = 1'b0;
    w_rx_done     = 1'b0;
    w_rx_ferr     = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_baud_n = '0;
        w_rx_brk_n  = 1'b0;
        if (r_rx_prev & ~r_rx_s2) w_rx_state_n = S_START;
      end
      S_START: if (r_rx_baud == BAUD_HALF) begin
        w_rx_baud_n  = '0;
        w_rx_bit_n   = '0;
        w_rx_state_n = r_rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: if (w_rx_end) begin
        w_rx_baud_n   = '0;
        w_rx_shift_en = 1'b1;
        if (r_rx_bit == 3'd7) w_rx_state_n = S_STOP;
        else                  w_rx_bit_n   = r_rx_bit + 3'd1;
      end
      S_STOP: begin
        // After a bad stop bit, hold here until the line returns high.
        if (r_rx_brk) begin
          w_rx_baud_n = '0;
          if (r_rx_s2) w_rx_state_n = S_IDLE;
        end else if (w_rx_end) begin
          w_rx_baud_n = '0;
          if (r_rx_s2) begin
            w_rx_done    = 1'b1;
            w_rx_state_n = S_IDLE;
          end else begin
            w_rx_ferr  = 1'b1;
            w_rx_brk_n = 1'b1;
          end
        end
      end
      default: w_rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_brk   <= 1'b0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_n;
      r_rx_baud  <= w_rx_baud_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_brk   <= w_rx_brk_n;
    end
  end

  always_ff @(posedge clock) begin
    if (w_rx_shift_en) r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
  end

  // Status flags; a set event takes priority over a CPU clear in the same cycle.
  logic       r_rx_ready, r_overrun, r_ferr, r_tx_ovf, r_irq;
  logic [7:0] r_rx_data;
  logic [7:0] w_status;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_ready <= 1'b0;
      r_overrun  <= 1'b0;
      r_ferr     <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_rx_data  <= '0;
      r_irq      <= 1'b1;
    end else begin
      if (w_rx_done)                      r_rx_ready <= 1'b1;
      else if (w_wr_stat & writeDataBus[0]) r_rx_ready <= 1'b0;
      if (w_rx_done & r_rx_ready & ~(w_wr_stat & writeDataBus[0])) r_overrun <= 1'b1;
      else if (w_wr_stat & writeDataBus[2])                        r_overrun <= 1'b0;
      if (w_rx_ferr)                        r_ferr <= 1'b1;
      else if (w_wr_stat & writeDataBus[4]) r_ferr <= 1'b0;
      if (w_drop)                           r_tx_ovf <= 1'b1;
      else if (w_wr_stat & writeDataBus[5]) r_tx_ovf <= 1'b0;
      if (w_rx_done) r_rx_data <= r_rx_shift;
      r_irq <= r_rx_ready | w_tx_idle;
    end
  end

  assign w_status = {2'b00, r_tx_ovf, r_ferr, w_tx_idle, r_overrun, ~w_full, r_rx_ready};

  always_comb begin
    readDataBus = 8'h00;
    if (w_sel_stat)      readDataBus = w_status;
    else if (w_sel_data) readDataBus = r_rx_data;
  end

  assign selected = w_sel_stat | w_sel_data;
  assign tx       = r_tx;
  assign irq      = r_irq;

endmodule

// File: tb/tb_mux_uart.sv
// Scoreboarded bench for mux_uart: bus reads and decoded TX frames are checked
// by independent monitors against a flag/queue model of the serial port.
`timescale 1ns/1ps
module tb_mux_uart;
  localparam int          CPB  = 16;
  localparam logic [15:0] BASE = 16'hF200;
  localparam longint      FRAME_NS = 10 * CPB * 10;

  logic        clock = 1'b0, reset = 1'b1;
  logic [15:0] addressBus = 16'h0000;
  logic [7:0]  writeDataBus = 8'h00;
  logic        writeEnBus = 1'b0, rx = 1'b1;
  logic [7:0]  readDataBus;
  logic        selected, tx, irq;

  mux_uart #(.BASE(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .addressBus(addressBus), .writeDataBus(writeDataBus),
    .writeEnBus(writeEnBus), .readDataBus(readDataBus), .selected(selected),
    .rx(rx), .tx(tx), .irq(irq));

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;

  // Model of the port state as the CPU sees it.
  bit         m_rdy, m_ovr, m_ferr, m_txovf;
  logic [7:0] m_data;
  logic [7:0] exp_tx[$];
  longint     tx_starts[$];
  int         rst_epoch = 0;

  string      q_nm[$];
  logic [7:0] q_dat[$];
  logic       q_sel[$];
  logic       rd_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_status(input bit idle, input bit ready);
    return {2'b00, m_txovf, m_ferr, idle, m_ovr, ready, m_rdy};
  endfunction

  task automatic cpu_read(input string name, input logic [15:0] a, input logic [7:0] e,
                          input logic esel);
    @(posedge clock); #1;
    addressBus = a;
    q_nm.push_back(name); q_dat.push_back(e); q_sel.push_back(esel);
    rd_valid = 1'b1;
    @(negedge clock); #1;
    rd_valid = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(posedge clock); #1;
    addressBus = a; writeDataBus = d; writeEnBus = 1'b1;
    repeat (hold) @(posedge clock);
    #1 writeEnBus = 1'b0; addressBus = 16'h0000;
    if (a == BASE) begin
      if (d[0]) m_rdy = 1'b0;
      if (d[2]) m_ovr = 1'b0;
      if (d[4]) m_ferr = 1'b0;
      if (d[5]) m_txovf = 1'b0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] d, input bit accept, input int hold);
    if (accept) exp_tx.push_back(d);
    else        m_txovf = 1'b1;
    cpu_write(BASE + 16'd1, d, hold);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit stop);
    @(posedge clock); #1 rx = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (CPB) @(posedge clock);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clock);
    #1 rx = 1'b1;
    repeat (4) @(posedge clock);
    if (stop) begin
      if (m_rdy) m_ovr = 1'b1;
      m_rdy = 1'b1;
      m_data = d;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic wait_tx_drain(input string name);
    int t = 0;
    while (exp_tx.size() != 0 && t < 20000) begin
      @(posedge clock); t++;
    end
    repeat (20) @(posedge clock);
    check(name, exp_tx.size(), 0);
  endtask

  // Read-data monitor
  always @(negedge clock) begin
    if (rd_valid) begin
      if (q_nm.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_queue: read strobe with no expected value");
      end else begin
        string nm;
        nm = q_nm.pop_front();
        check({nm, "_data"}, readDataBus, q_dat.pop_front());
        check({nm, "_sel"}, selected, q_sel.pop_front());
      end
    end
  end

  // TX line monitor: decodes 8N1 frames at mid-bit.
  initial begin
    logic [7:0] b;
    logic       sb, stp;
    longint     st;
    int         ep;
    forever begin
      @(negedge tx);
      if (reset) continue;
      ep = rst_epoch; st = $time;
      repeat (CPB / 2) @(posedge clock);
      #1 sb = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clock);
        #1 b[i] = tx;
      end
      repeat (CPB) @(posedge clock);
      #1 stp = tx;
      if (ep == rst_epoch) begin
        tx_starts.push_back(st);
        check("tx_startbit", sb, 1'b0);
        check("tx_stopbit", stp, 1'b1);
        n_checks++;
        if (exp_tx.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got frame 0x%0h, expected no frame", b);
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          if (b !== e) begin
            n_fail++;
            $display("FAIL tx_byte: got 0x%0h, expected 0x%0h", b, e);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, lowcnt;
    logic [7:0] d;
    m_rdy = 0; m_ovr = 0; m_ferr = 0; m_txovf = 0; m_data = 8'h00;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq, 1'b1);
    @(posedge clock); #1 reset = 1'b0;
    cpu_read("rst_status", BASE, 8'h0A, 1'b1);
    check("idle_tx", tx, 1'b1);
    cpu_read("unmapped", 16'h1234, 8'h00, 1'b0);
    cpu_read("rst_rxdata", BASE + 16'd1, 8'h00, 1'b1);

    // One frame per write-enable high period
    tx_byte(8'hA5, 1'b1, 3);
    wait_tx_drain("drain_a5");
    cpu_read("a5_status", BASE, 8'h0A, 1'b1);

    // Overflow and back-to-back frames
    tx_starts.delete();
    tx_byte(8'h00, 1'b1, 1);
    for (int i = 1; i <= 5; i++) tx_byte(8'(i), i <= 4, 1);
    cpu_read("full_status", BASE, exp_status(1'b0, 1'b0), 1'b1);
    cpu_write(BASE, 8'h20, 1);
    cpu_read("ovf_clear", BASE, exp_status(1'b0, 1'b0), 1'b1);
    wait_tx_drain("drain_burst");
    check("burst_frames", tx_starts.size(), 5);
    if (tx_starts.size() == 5)
      for (int i = 1; i < 5; i++)
        check("b2b_gap", 32'(tx_starts[i] - tx_starts[i-1]), 32'(FRAME_NS));
    cpu_read("burst_status", BASE, 8'h0A, 1'b1);

    // RX basic receive and clear
    send_rx(8'h3C, 1'b1);
    cpu_read("rx_status", BASE, exp_status(1'b1, 1'b1), 1'b1);
    cpu_read("rx_data", BASE + 16'd1, m_data, 1'b1);
    @(negedge clock);
    check("rx_irq", irq, 1'b1);
    cpu_write(BASE, 8'h01, 1);
    cpu_read("rx_clear", BASE, exp_status(1'b1, 1'b1), 1'b1);

    // Overrun, framing error, glitch rejection
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    cpu_read("ovr_status", BASE, exp_status(1'b1, 1'b1), 1'b1);
    cpu_read("ovr_data", BASE + 16'd1, 8'h22, 1'b1);
    send_rx(8'h77, 1'b0);
    cpu_read("ferr_status", BASE, exp_status(1'b1, 1'b1), 1'b1);
    cpu_read("ferr_data", BASE + 16'd1, 8'h22, 1'b1);
    @(posedge clock); #1 rx = 1'b0;
    repeat (4) @(posedge clock);
    #1 rx = 1'b1;
    repeat (40) @(posedge clock);
    cpu_read("glitch_status", BASE, exp_status(1'b1, 1'b1), 1'b1);
    cpu_read("glitch_data", BASE + 16'd1, 8'h22, 1'b1);
    cpu_write(BASE, 8'h35, 1);
    cpu_read("clear_all", BASE, 8'h0A, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) tx_byte(8'($urandom), 1'b1, $urandom_range(1, 3));
      k = $urandom_range(1, 2);
      for (int i = 0; i < k; i++) send_rx(8'($urandom), ($urandom_range(0, 3) != 0));
      wait_tx_drain("rnd_drain");
      cpu_read("rnd_status", BASE, exp_status(1'b1, 1'b1), 1'b1);
      cpu_read("rnd_data", BASE + 16'd1, m_data, 1'b1);
      d = 8'($urandom);
      cpu_write(BASE, d, 1);
      cpu_read("rnd_clr_status", BASE, exp_status(1'b1, 1'b1), 1'b1);
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rnd_irq", irq, 1'b1);
    end

    // Reset in the middle of a frame
    tx_byte(8'h5A, 1'b1, 1);
    tx_byte(8'hC3, 1'b1, 1);
    repeat (50) @(posedge clock);
    #3;
    rst_epoch++;
    exp_tx.delete();
    reset = 1'b1;
    m_rdy = 0; m_ovr = 0; m_ferr = 0; m_txovf = 0; m_data = 8'h00;
    #1 check("midrst_tx", tx, 1'b1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    cpu_read("midrst_status", BASE, 8'h0A, 1'b1);
    lowcnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) lowcnt++;
    end
    check("midrst_tx_quiet", lowcnt, 0);
    cpu_read("midrst_rxdata", BASE + 16'd1, 8'h00, 1'b1);

    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
